// File: rtl/edge_map_scanner.sv
// Sweeps the binary edge map in frame memory once per enable, counting edge
// pixels and tracking their bounding box; read-only bus master, tri-stated when idle.
module edge_map_scanner #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned FIRST_ADDR = 2240,
    parameter int unsigned LAST_ADDR  = 74560,
    parameter int unsigned FIRST_LINE = 7
) (
    input  logic        clk_div_by_two,
    input  logic        reset,
    input  logic        enable_edge_scan,
    input  logic [31:0] data_read,
    output logic [17:0] address,
    output logic        wren,
    output logic        edge_scan_done,
    output logic [16:0] edge_count,
    output logic        box_valid,
    output logic [8:0]  min_x,
    output logic [8:0]  max_x,
    output logic [7:0]  min_y,
    output logic [7:0]  max_y
);

    localparam logic [17:0] ADDR_FIRST = 18'(FIRST_ADDR);
    localparam logic [17:0] ADDR_LAST  = 18'(LAST_ADDR);
    localparam logic [8:0]  X_LAST     = 9'(IMG_WIDTH - 1);
    localparam logic [7:0]  Y_FIRST    = 8'(FIRST_LINE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    // Coordinates of the address currently on the bus; they line up with
    // the data_read word sampled on the next edge.
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;

    logic [16:0] acc_cnt_q, acc_cnt_d;
    logic [8:0]  acc_min_x_q, acc_min_x_d, acc_max_x_q, acc_max_x_d;
    logic [7:0]  acc_min_y_q, acc_min_y_d, acc_max_y_q, acc_max_y_d;

    logic        done_q, done_d;
    logic [16:0] edge_count_q, edge_count_d;
    logic        box_valid_q, box_valid_d;
    logic [8:0]  min_x_q, min_x_d, max_x_q, max_x_d;
    logic [7:0]  min_y_q, min_y_d, max_y_q, max_y_d;

    logic        hit;
    logic [16:0] s_cnt;
    logic [8:0]  s_min_x, s_max_x;
    logic [7:0]  s_min_y, s_max_y;
    logic        unused_data;

    assign unused_data = ^data_read[31:1];
    assign hit         = data_read[0];

    // Accumulators with the current sample folded in
    always_comb begin
        s_cnt   = acc_cnt_q + {16'd0, hit};
        s_min_x = (hit && (x_q < acc_min_x_q)) ? x_q : acc_min_x_q;
        s_max_x = (hit && (x_q > acc_max_x_q)) ? x_q : acc_max_x_q;
        s_min_y = (hit && (y_q < acc_min_y_q)) ? y_q : acc_min_y_q;
        s_max_y = (hit && (y_q > acc_max_y_q)) ? y_q : acc_max_y_q;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        x_d          = x_q;
        y_d          = y_q;
        acc_cnt_d    = acc_cnt_q;
        acc_min_x_d  = acc_min_x_q;
        acc_max_x_d  = acc_max_x_q;
        acc_min_y_d  = acc_min_y_q;
        acc_max_y_d  = acc_max_y_q;
        done_d       = done_q;
        edge_count_d = edge_count_q;
        box_valid_d  = box_valid_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (enable_edge_scan) begin
                    addr_d      = ADDR_FIRST;
                    x_d         = '0;
                    y_d         = Y_FIRST;
                    acc_cnt_d   = '0;
                    acc_min_x_d = '1;
                    acc_min_y_d = '1;
                    acc_max_x_d = '0;
                    acc_max_y_d = '0;
                    state_d     = (ADDR_FIRST == ADDR_LAST) ? ST_DRAIN : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enable_edge_scan) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_cnt_d   = s_cnt;
                    acc_min_x_d = s_min_x;
                    acc_max_x_d = s_max_x;
                    acc_min_y_d = s_min_y;
                    acc_max_y_d = s_max_y;
                    addr_d      = addr_q + 18'd1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 8'd1;
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                    if (addr_d == ADDR_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!enable_edge_scan) begin
                    state_d = ST_IDLE;
                end else begin
                    edge_count_d = s_cnt;
                    box_valid_d  = (s_cnt != '0);
                    min_x_d      = (s_cnt != '0) ? s_min_x : '0;
                    max_x_d      = (s_cnt != '0) ? s_max_x : '0;
                    min_y_d      = (s_cnt != '0) ? s_min_y : '0;
                    max_y_d      = (s_cnt != '0) ? s_max_y : '0;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!enable_edge_scan) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_div_by_two or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            acc_cnt_q    <= '0;
            acc_min_x_q  <= '0;
            acc_max_x_q  <= '0;
            acc_min_y_q  <= '0;
            acc_max_y_q  <= '0;
            done_q       <= 1'b0;
            edge_count_q <= '0;
            box_valid_q  <= 1'b0;
            min_x_q      <= '0;
            max_x_q      <= '0;
            min_y_q      <= '0;
            max_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_min_x_q  <= acc_min_x_d;
            acc_max_x_q  <= acc_max_x_d;
            acc_min_y_q  <= acc_min_y_d;
            acc_max_y_q  <= acc_max_y_d;
            done_q       <= done_d;
            edge_count_q <= edge_count_d;
            box_valid_q  <= box_valid_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
        end
    end

    assign address        = (state_q != ST_IDLE) ? addr_q : 'z;
    assign wren           = (state_q != ST_IDLE) ? 1'b0 : 1'bz;
    assign edge_scan_done = done_q;
    assign edge_count     = edge_count_q;
    assign box_valid      = box_valid_q;
    assign min_x          = min_x_q;
    assign max_x          = max_x_q;
    assign min_y          = min_y_q;
    assign max_y          = max_y_q;

endmodule

// File: tb/tb_edge_map_scanner.sv
// Directed bench for edge_map_scanner on a reduced map (8-pixel lines, lines 2..7)
// so several full sweeps fit in a short run.
module tb_edge_map_scanner;

    localparam int unsigned W  = 8;
    localparam int unsigned FL = 2;
    localparam int unsigned FA = 16;
    localparam int unsigned LA = 63;
    localparam int N = LA - FA + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] data_read;
    wire  [17:0] address;
    wire         wren;
    logic        done;
    logic [16:0] edge_count;
    logic        box_valid;
    logic [8:0]  min_x, max_x;
    logic [7:0]  min_y, max_y;

    logic [31:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    edge_map_scanner #(
        .IMG_WIDTH (W),
        .FIRST_ADDR(FA),
        .LAST_ADDR (LA),
        .FIRST_LINE(FL)
    ) dut (
        .clk_div_by_two  (clk),
        .reset           (reset),
        .enable_edge_scan(enable),
        .data_read       (data_read),
        .address         (address),
        .wren            (wren),
        .edge_scan_done  (done),
        .edge_count      (edge_count),
        .box_valid       (box_valid),
        .min_x           (min_x),
        .max_x           (max_x),
        .min_y           (min_y),
        .max_y           (max_y)
    );

    always #5 clk = ~clk;

    // Memory answers mid-cycle, so the word is ready at the next rising edge
    always @(negedge clk) begin
        data_read = mem[address[6:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [51:0] results();
        return {edge_count, box_valid, min_x, max_x, min_y, max_y};
    endfunction

    function automatic logic bus_released();
        return ((address === 18'bz) || (address === 18'd0)) &&
               ((wren === 1'bz) || (wren === 1'b0));
    endfunction

    task automatic clear_mem(input logic [31:0] fill);
        for (int i = 0; i < 128; i++) mem[i] = fill;
    endtask

    task automatic run_scan(output int done_edge, output int addr_err, output int wren_err);
        enable    = 1'b1;
        done_edge = -1;
        addr_err  = 0;
        wren_err  = 0;
        for (int i = 0; i <= N + 8; i++) begin
            @(posedge clk); #1;
            if (wren !== 1'b0) wren_err++;
            if (i < N) begin
                if (address !== 18'(FA + i)) addr_err++;
            end else if (address !== 18'(LA)) begin
                addr_err++;
            end
            if (done === 1'b1) begin
                done_edge = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        clear_mem('0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (results() !== 52'd0) begin
            errors++; $display("FAIL reset_results: got %h expected %h", results(), 52'd0);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (!bus_released()) begin
            errors++; $display("FAIL reset_bus: address %h wren %b expected released", address, wren);
        end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic finish_scan(input string name);
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL %s_done_drop: got %b expected 0", name, done);
        end
        checks++;
        if (!bus_released()) begin
            errors++; $display("FAIL %s_bus_idle: address %h wren %b expected released", name, address, wren);
        end
    endtask

    task automatic test_single();
        int de, ae, we;
        logic [51:0] exp_r;
        clear_mem('0);
        mem[FA + 3 * W + 5] = 32'd1;
        exp_r = {17'd1, 1'b1, 9'd5, 9'd5, 8'd5, 8'd5};
        run_scan(de, ae, we);
        checks++;
        if (de !== N) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", de, N);
        end
        checks++;
        if (results() !== exp_r) begin
            errors++; $display("FAIL single_results: got %h expected %h", results(), exp_r);
        end
        checks++;
        if (we !== 0) begin
            errors++; $display("FAIL single_wren: got %0d bad cycles expected 0", we);
        end
        finish_scan("single");
    endtask

    task automatic test_first_last();
        int de, ae, we;
        logic [51:0] exp_r;
        clear_mem('0);
        mem[FA] = 32'd1;
        mem[LA] = 32'd1;
        exp_r = {17'd2, 1'b1, 9'd0, 9'd7, 8'd2, 8'd7};
        run_scan(de, ae, we);
        checks++;
        if (de !== N) begin
            errors++; $display("FAIL first_last_latency: got %0d expected %0d", de, N);
        end
        checks++;
        if (results() !== exp_r) begin
            errors++; $display("FAIL first_last_results: got %h expected %h", results(), exp_r);
        end
        finish_scan("first_last");
    endtask

    task automatic test_all_zero();
        int de, ae, we;
        // Upper bits set everywhere; only bit0 may count
        clear_mem(32'hFFFF_FFFE);
        run_scan(de, ae, we);
        checks++;
        if (de !== N) begin
            errors++; $display("FAIL all_zero_latency: got %0d expected %0d", de, N);
        end
        checks++;
        if (results() !== 52'd0) begin
            errors++; $display("FAIL all_zero_results: got %h expected %h", results(), 52'd0);
        end
        checks++;
        if (we !== 0) begin
            errors++; $display("FAIL all_zero_wren: got %0d bad cycles expected 0", we);
        end
        finish_scan("all_zero");
    endtask

    task automatic test_address_trace();
        int de, ae, we;
        logic [51:0] exp_r;
        clear_mem('0);
        mem[FA + 1 * W + 7] = 32'h0000_0003;
        mem[FA + 2 * W + 0] = 32'h0000_0001;
        mem[FA + 4 * W + 2] = 32'h8000_0001;
        exp_r = {17'd3, 1'b1, 9'd0, 9'd7, 8'd3, 8'd6};
        run_scan(de, ae, we);
        checks++;
        if (ae !== 0) begin
            errors++; $display("FAIL trace_addresses: got %0d wrong addresses expected 0", ae);
        end
        checks++;
        if (de !== N) begin
            errors++; $display("FAIL trace_latency: got %0d expected %0d", de, N);
        end
        checks++;
        if (results() !== exp_r) begin
            errors++; $display("FAIL trace_results: got %h expected %h", results(), exp_r);
        end
        finish_scan("trace");
    endtask

    task automatic test_abort();
        int de, ae, we;
        logic [51:0] prev_r, exp_r;
        prev_r = {17'd3, 1'b1, 9'd0, 9'd7, 8'd3, 8'd6};
        exp_r  = {17'd2, 1'b1, 9'd4, 9'd4, 8'd2, 8'd7};
        clear_mem('0);
        mem[20] = 32'd1;
        mem[60] = 32'd1;
        enable = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL abort_done: got %b expected 0", done);
        end
        checks++;
        if (results() !== prev_r) begin
            errors++; $display("FAIL abort_hold: got %h expected %h", results(), prev_r);
        end
        checks++;
        if (!bus_released()) begin
            errors++; $display("FAIL abort_bus: address %h wren %b expected released", address, wren);
        end
        run_scan(de, ae, we);
        checks++;
        if (ae !== 0) begin
            errors++; $display("FAIL abort_restart_addr: got %0d wrong addresses expected 0", ae);
        end
        checks++;
        if (results() !== exp_r) begin
            errors++; $display("FAIL abort_restart_results: got %h expected %h", results(), exp_r);
        end
        finish_scan("abort");
    endtask

    task automatic test_reset_mid_scan();
        int de, ae, we;
        logic [51:0] exp_r;
        exp_r = {17'd2, 1'b1, 9'd4, 9'd4, 8'd2, 8'd7};
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (results() !== 52'd0) begin
            errors++; $display("FAIL midreset_results: got %h expected %h", results(), 52'd0);
        end
        checks++;
        if (!bus_released() || done !== 1'b0) begin
            errors++; $display("FAIL midreset_bus: address %h wren %b done %b expected released/0", address, wren, done);
        end
        #2 reset = 1'b0;
        run_scan(de, ae, we);
        checks++;
        if (de !== N || ae !== 0) begin
            errors++; $display("FAIL midreset_rescan: got latency %0d addr errs %0d expected %0d/0", de, ae, N);
        end
        checks++;
        if (results() !== exp_r) begin
            errors++; $display("FAIL midreset_results_after: got %h expected %h", results(), exp_r);
        end
        finish_scan("midreset");
    endtask

    initial begin
        data_read = '0;
        test_reset();
        test_single();
        test_first_last();
        test_all_zero();
        test_address_trace();
        test_abort();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
